// File: rtl/shift_cnt_multi_pkg.sv
// Shared constants and helpers for the ring/Johnson shift counter.
package shift_cnt_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    // Index width wide enough for the 2*width Johnson states.
    function automatic int idx_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/shift_cnt_multi_if.sv
// Control/status bundle of the shift counter; the sequencer owner is master.
interface shift_cnt_multi_if
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int IW = idx_w(WIDTH);

    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [IW-1:0]    idx;
    logic             valid;
    logic             wrap;
    logic             err;

    modport master (
        output en, mode, dir, load, load_val,
        input  q, idx, valid, wrap, err
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output q, idx, valid, wrap, err
    );
endinterface

// File: rtl/shift_cnt_multi_decode.sv
// Combinational decode of a counter pattern into a state index and legality flag.
module shift_cnt_decode
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IW   = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic [IW-1:0]    idx,
    output logic             valid
);
    localparam int             NS  = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ALL = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] ring_hit;
    logic [NS-1:0]    john_hit;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ring
            assign ring_hit[gi] = (q == (ONE << gi));
        end
        // Johnson states 0..W are k ones at the LSBs; W+z are z zeros under a block of ones.
        for (gi = 0; gi < NS; gi++) begin : g_john
            if (gi <= WIDTH) begin : g_fill
                localparam logic [WIDTH-1:0] PAT = ALL >> (WIDTH - gi);
                assign john_hit[gi] = (q == PAT);
            end else begin : g_drain
                localparam logic [WIDTH-1:0] PAT = ~(ALL >> (2 * WIDTH - gi));
                assign john_hit[gi] = (q == PAT);
            end
        end
    endgenerate

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        if (mode == MODE_RING) begin
            if (q == '0) begin
                valid = 1'b1;
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (ring_hit[i]) begin
                    valid = 1'b1;
                    idx   = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (john_hit[i]) begin
                    valid = 1'b1;
                    idx   = IW'(i);
                end
            end
        end
    end
endmodule

// File: rtl/shift_cnt_multi.sv
// Ring/Johnson shift-register counter with load, direction, index decode and wrap pulse.
// Optional build macro SHIFT_CNT_SELFCORRECT_EN: illegal patterns are reseeded on en, with an err pulse.
module shift_cnt_multi
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              start,
    shift_cnt_multi_if.slave  bus
);
    localparam int               IW        = idx_w(WIDTH);
    localparam logic [WIDTH-1:0] SEED_RING = WIDTH'(1);
    localparam logic [IW-1:0]    MAX_RING  = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    MAX_JOHN  = IW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] q_reg, q_next, shifted;
    logic             wrap_reg, wrap_next;
    logic             err_reg, err_next;
    logic [IW-1:0]    idx, idx_max;
    logic             valid, fb_left, fb_right, ring_seed;

    shift_cnt_decode #(.WIDTH(WIDTH)) u_decode (
        .q     (q_reg),
        .mode  (bus.mode),
        .idx   (idx),
        .valid (valid)
    );

    always_comb begin
        fb_left   = (bus.mode == MODE_JOHNSON) ? ~q_reg[WIDTH-1] : q_reg[WIDTH-1];
        fb_right  = (bus.mode == MODE_JOHNSON) ? ~q_reg[0]       : q_reg[0];
        shifted   = (bus.dir == DIR_LEFT) ? {q_reg[WIDTH-2:0], fb_left}
                                          : {fb_right, q_reg[WIDTH-1:1]};
        ring_seed = (bus.mode == MODE_RING) && (q_reg == '0);
        idx_max   = (bus.mode == MODE_RING) ? MAX_RING : MAX_JOHN;
    end

    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (bus.load) begin
            q_next = bus.load_val;
        end else if (bus.en) begin
`ifdef SHIFT_CNT_SELFCORRECT_EN
            if (!valid) begin
                q_next   = (bus.mode == MODE_RING) ? SEED_RING : '0;
                err_next = 1'b1;
            end else
`endif
            // Empty ring register has no token to rotate, so it is seeded without a wrap.
            if (ring_seed) begin
                q_next = SEED_RING;
            end else begin
                q_next    = shifted;
                wrap_next = valid && ((bus.dir == DIR_LEFT) ? (idx == idx_max) : (idx == '0));
            end
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
            err_reg  <= err_next;
        end
    end

    assign bus.q     = q_reg;
    assign bus.idx   = idx;
    assign bus.valid = valid;
    assign bus.wrap  = wrap_reg;
`ifdef SHIFT_CNT_SELFCORRECT_EN
    assign bus.err   = err_reg;
`else
    assign bus.err   = 1'b0;
`endif
endmodule
